sprite_mixer: RTL

Parametrised N-layer sprite compositor for the Pocket_lab game designs. It sits between the video timing generator and the RGB output and replaces the fixed bird/tube/banner display logic. Each of its sprite channels has a position, a size, a 2^k scale and a ROM base. The block generates ROM addresses, keys out transparent pixels, merges layers by fixed priority over a tiled background and draws a frame border. Sprite parameters are double-buffered per frame, and the block reports per-frame collisions between sprite 0 and every other sprite.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_channel.sv | 63 ++++++
 rtl/sprite_mixer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite compositor.
// The shadow and active sprite sets share one config struct.
package sprite_pkg;

    localparam logic [11:0] KEY_COLOR_DEF    = 12'h000;
    localparam logic [11:0] BORDER_COLOR_DEF = 12'h555;

    localparam int SPR_COORD_W = 12;
    localparam int SPR_ADDR_W  = 12;

    typedef struct packed {
        logic                   en;
        logic [SPR_COORD_W-1:0] x;
        logic [SPR_COORD_W-1:0] y;
        logic [7:0]             w;
        logic [7:0]             h;
        logic [1:0]             scale;
        logic [SPR_ADDR_W-1:0]  base;
    } spr_cfg_t;

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: frame-latched active set, hit test and
// sprite ROM address generation (stage 1).
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int COORD_W = SPR_COORD_W,
    parameter int ADDR_W  = SPR_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  spr_cfg_t           shd,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic               hit,
    output logic [ADDR_W-1:0]  rom_addr
);

    spr_cfg_t           act;
    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic [COORD_W:0]   w_sc;
    logic [COORD_W:0]   h_sc;
    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W+7:0] prod;
    logic [31:0]        addr_sum;
    logic               hit_c;

    // Extents are one bit wider so a sprite past the edge never wraps.
    always_comb begin
        sx       = act.x[COORD_W-1:0];
        sy       = act.y[COORD_W-1:0];
        w_sc     = (COORD_W+1)'(act.w) << act.scale;
        h_sc     = (COORD_W+1)'(act.h) << act.scale;
        x_end    = {1'b0, sx} + w_sc;
        y_end    = {1'b0, sy} + h_sc;
        hit_c    = act.en
                 && (x_in >= sx) && ({1'b0, x_in} < x_end)
                 && (y_in >= sy) && ({1'b0, y_in} < y_end);
        dx       = (x_in - sx) >> act.scale;
        dy       = (y_in - sy) >> act.scale;
        prod     = {8'd0, dy} * {{COORD_W{1'b0}}, act.w};
        addr_sum = 32'(act.base) + 32'(prod) + 32'(dx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act      <= '0;
            hit      <= 1'b0;
            rom_addr <= '0;
        end else begin
            if (load)
                act <= shd;
            hit <= hit_c;
            if (hit_c)
                rom_addr <= addr_sum[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/sprite_mixer.sv
// N-layer sprite compositor: 3-cycle pixel pipeline, border, bg tiles.
// Optional per-frame collision flags under SPRITE_COLLISION_EN.
module sprite_mixer
    import sprite_pkg::*;
#(
    parameter int                N_SPR        = 4,
    parameter int                COORD_W      = SPR_COORD_W,
    parameter int                PIX_W        = 12,
    parameter int                ADDR_W       = SPR_ADDR_W,
    parameter logic [PIX_W-1:0]  KEY_COLOR    = PIX_W'(KEY_COLOR_DEF),
    parameter int                H_ACT        = 640,
    parameter int                V_ACT        = 480,
    parameter int                BORDER       = 5,
    parameter logic [PIX_W-1:0]  BORDER_COLOR = PIX_W'(BORDER_COLOR_DEF),
    parameter int                BG_SHIFT     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hs_in,
    input  logic                      vs_in,
    input  logic                      de_in,
    input  logic [COORD_W-1:0]        x_in,
    input  logic [COORD_W-1:0]        y_in,
    input  logic [N_SPR-1:0]          spr_en,
    input  logic [N_SPR*COORD_W-1:0]  spr_x,
    input  logic [N_SPR*COORD_W-1:0]  spr_y,
    input  logic [N_SPR*8-1:0]        spr_w,
    input  logic [N_SPR*8-1:0]        spr_h,
    input  logic [N_SPR*2-1:0]        spr_scale,
    input  logic [N_SPR*ADDR_W-1:0]   spr_base,
    output logic [N_SPR*ADDR_W-1:0]   rom_addr,
    input  logic [N_SPR*PIX_W-1:0]    rom_data,
    output logic [15:0]               bg_addr,
    input  logic [PIX_W-1:0]          bg_data,
    output logic                      hs_out,
    output logic                      vs_out,
    output logic                      de_out,
    output logic [PIX_W-1:0]          data_out,
    output logic [N_SPR-2:0]          collision,
    output logic                      coll_valid
);

    localparam logic [COORD_W-1:0] B_LO = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(H_ACT - BORDER);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(V_ACT - BORDER);

    logic               vs_d;
    logic               frame_edge;
    logic [N_SPR-1:0]   hit1;
    logic [N_SPR-1:0]   hit2;
    logic               de1, hs1, vs1;
    logic               de2, hs2, vs2;
    logic [COORD_W-1:0] x1, y1, x2, y2;
    logic [31:0]        bg_sum;
    logic [N_SPR-1:0]   opaque;
    logic               border2;
    logic [PIX_W-1:0]   pix_n;

    assign frame_edge = vs_in & ~vs_d;

    for (genvar i = 0; i < N_SPR; i++) begin : g_ch
        spr_cfg_t shd;
        assign shd.en    = spr_en[i];
        assign shd.x     = spr_x[i*COORD_W +: COORD_W];
        assign shd.y     = spr_y[i*COORD_W +: COORD_W];
        assign shd.w     = spr_w[i*8 +: 8];
        assign shd.h     = spr_h[i*8 +: 8];
        assign shd.scale = spr_scale[i*2 +: 2];
        assign shd.base  = spr_base[i*ADDR_W +: ADDR_W];

        sprite_channel #(
            .COORD_W (COORD_W),
            .ADDR_W  (ADDR_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .load     (frame_edge),
            .shd      (shd),
            .x_in     (x_in),
            .y_in     (y_in),
            .hit      (hit1[i]),
            .rom_addr (rom_addr[i*ADDR_W +: ADDR_W])
        );
    end

    assign bg_sum = 32'(x_in >> BG_SHIFT)
                  + 32'(y_in >> BG_SHIFT) * 32'(H_ACT >> BG_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d    <= 1'b0;
            bg_addr <= '0;
            {de1, hs1, vs1} <= '0;
            {de2, hs2, vs2} <= '0;
            x1 <= '0;
            y1 <= '0;
            x2 <= '0;
            y2 <= '0;
            hit2 <= '0;
        end else begin
            vs_d    <= vs_in;
            bg_addr <= bg_sum[15:0];
            {de1, hs1, vs1} <= {de_in, hs_in, vs_in};
            {de2, hs2, vs2} <= {de1, hs1, vs1};
            x1 <= x_in;
            y1 <= y_in;
            x2 <= x1;
            y2 <= y1;
            hit2 <= hit1;
        end
    end

    // Lowest index wins, so scan from the top down.
    always_comb begin
        opaque = '0;
        pix_n  = bg_data;
        for (int i = 0; i < N_SPR; i++)
            opaque[i] = hit2[i] &&
                        (rom_data[i*PIX_W +: PIX_W] != KEY_COLOR);
        for (int i = N_SPR - 1; i >= 0; i--)
            if (opaque[i])
                pix_n = rom_data[i*PIX_W +: PIX_W];
        border2 = (x2 < B_LO) || (x2 >= X_HI) ||
                  (y2 < B_LO) || (y2 >= Y_HI);
        if (border2)
            pix_n = BORDER_COLOR;
        if (!de2)
            pix_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            {de_out, hs_out, vs_out} <= '0;
        end else begin
            data_out <= pix_n;
            {de_out, hs_out, vs_out} <= {de2, hs2, vs2};
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [N_SPR-2:0] sticky;
    logic [N_SPR-2:0] coll_hit;
    logic             edge3;

    assign edge3 = vs2 & ~vs_out;

    always_comb begin
        coll_hit = '0;
        for (int i = 1; i < N_SPR; i++)
            coll_hit[i-1] = de2 && opaque[0] && opaque[i];
    end

    // Clear before set: a hit on the edge cycle belongs to the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky     <= '0;
            collision  <= '0;
            coll_valid <= 1'b0;
        end else begin
            coll_valid <= edge3;
            if (edge3) begin
                collision <= sticky;
                sticky    <= coll_hit;
            end else begin
                sticky <= sticky | coll_hit;
            end
        end
    end
`else
    assign collision  = '0;
    assign coll_valid = 1'b0;
`endif

endmodule
